// File: rtl/keyboard_event_ctrl.sv
// keyboard_event_ctrl: assembles PS/2 set-2 scan-code bytes into key events
// {extended, released, code}. It handles E0/F0 prefixes, swallows the
// E1 Pause sequence, drops device status bytes, and queues events in a
// show-ahead FIFO that the CPU drains.
module keyboard_event_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int PREFIX_TIMEOUT = 2000000,
    parameter int TIMEOUT_W      = 21
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    keyboard_code,
    input  logic                          keyboard_strobe,
    input  logic                          rd_en,
    input  logic                          clr_overflow,
    output logic [9:0]                    event_data,
    output logic                          event_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(PREFIX_TIMEOUT);
    localparam logic [CW-1:0]        FULL_COUNT   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_SKIP
    } state_t;

    state_t                r_state;
    state_t                w_curState;
    state_t                w_nextState;
    logic [TIMEOUT_W-1:0]  r_timeout;
    logic [2:0]            r_skip;
    logic [2:0]            w_nextSkip;
    logic                  w_expired;
    logic                  w_push;
    logic [9:0]            w_pushData;

    logic [9:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_doPush;
    logic                  w_drop;

    // Bytes the keyboard sends about itself rather than about a key
    function automatic logic isStatus(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFC) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // A stalled partial sequence behaves as IDLE in the cycle its timer hits zero.
    // This lets a strobe arriving in that same cycle start a fresh sequence.
    assign w_expired  = (r_state != S_IDLE) && (r_timeout == '0);
    assign w_curState = w_expired ? S_IDLE : r_state;

    // Parser next-state: decides state, skip count and whether a finished event is pushed
    always_comb begin
        w_nextState = w_curState;
        w_nextSkip  = w_expired ? 3'd0 : r_skip;
        w_push      = 1'b0;
        w_pushData  = 10'd0;
        if (keyboard_strobe) begin
            unique case (w_curState)
                S_IDLE: begin
                    if (keyboard_code == 8'hE0) begin
                        w_nextState = S_EXT;
                    end else if (keyboard_code == 8'hF0) begin
                        w_nextState = S_BRK;
                    end else if (keyboard_code == 8'hE1) begin
                        w_nextState = S_SKIP;
                        w_nextSkip  = 3'd7;
                    end else if (!isStatus(keyboard_code)) begin
                        w_push     = 1'b1;
                        w_pushData = {2'b00, keyboard_code};
                    end
                end
                S_EXT: begin
                    if (keyboard_code == 8'hF0) begin
                        w_nextState = S_EXTBRK;
                    end else begin
                        w_nextState = S_IDLE;
                        if (keyboard_code != 8'hE0 && keyboard_code != 8'hE1 &&
                            !isStatus(keyboard_code)) begin
                            w_push     = 1'b1;
                            w_pushData = {2'b10, keyboard_code};
                        end
                    end
                end
                S_BRK, S_EXTBRK: begin
                    w_nextState = S_IDLE;
                    if (keyboard_code != 8'hE0 && keyboard_code != 8'hF0 &&
                        keyboard_code != 8'hE1 && !isStatus(keyboard_code)) begin
                        w_push     = 1'b1;
                        w_pushData = {(w_curState == S_EXTBRK), 1'b1, keyboard_code};
                    end
                end
                S_SKIP: begin
                    if (r_skip <= 3'd1) begin
                        w_nextState = S_IDLE;
                        w_nextSkip  = 3'd0;
                    end else begin
                        w_nextSkip = r_skip - 3'd1;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // Parser registers: state, skip count, and the inter-byte timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_skip    <= 3'd0;
            r_timeout <= '0;
        end else begin
            r_state <= w_nextState;
            r_skip  <= w_nextSkip;
            if (w_nextState == S_IDLE) begin
                r_timeout <= '0;
            end else if (keyboard_strobe) begin
                r_timeout <= TIMEOUT_LOAD;
            end else begin
                r_timeout <= r_timeout - TIMEOUT_W'(1);
            end
        end
    end

    assign w_full   = (r_count == FULL_COUNT);
    assign w_pop    = rd_en && (r_count != '0);
    assign w_doPush = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    // Event storage: the storage array itself needs no reset because the output is gated by event_valid
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            unique case ({w_doPush, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a dropped event wins over a clear in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign event_valid = (r_count != '0);
    assign event_data  = event_valid ? r_mem[r_rdPtr] : 10'd0;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign irq         = event_valid | r_overflow;

endmodule
